// File: rtl/fdivsqrt_seq_pkg.sv
//------------------------------------------------------------------------------
// Module      : fdivsqrt_seq_pkg
// Description : Shared types and helpers for the div/sqrt control sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fdivsqrt_seq_pkg;

    typedef enum logic [1:0] {
        FDIVSQRT_IDLE = 2'b00,
        FDIVSQRT_BUSY = 2'b01,
        FDIVSQRT_DONE = 2'b10
    } fdivsqrt_state_t;

    localparam int c_default_cntw = 7;

    // A zero cycle request still runs one iteration so the datapath is loaded.
    function automatic logic [c_default_cntw-1:0] fdivsqrt_min_one(
        input logic [c_default_cntw-1:0] cycles
    );
        return (cycles == '0) ? c_default_cntw'(1) : cycles;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fdivsqrt_seq_stepcnt.sv
//------------------------------------------------------------------------------
// Module      : fdivsqrt_stepcnt
// Description : Loadable iteration down-counter with synchronous clear and ==1 flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fdivsqrt_stepcnt #(
    parameter int CNTW = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clr,
    input  logic            i_load,
    input  logic [CNTW-1:0] i_load_val,
    input  logic            i_dec,
    output logic [CNTW-1:0] o_step,
    output logic            o_step_is_one
);

    logic [CNTW-1:0] r_step;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_step <= '0;
        end else if (i_load) begin
            r_step <= i_load_val;
        end else if (i_dec) begin
            r_step <= r_step - 1'b1;
        end
    end

    assign o_step        = r_step;
    assign o_step_is_one = (r_step == CNTW'(1));

endmodule

`default_nettype wire

// File: rtl/fdivsqrt_seq.sv
//------------------------------------------------------------------------------
// Module      : fdivsqrt_seq
// Description : Control sequencer for the iterative divide/square-root datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fdivsqrt_seq
    import fdivsqrt_seq_pkg::*;
#(
    parameter int CNTW = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FDivStartE,
    input  logic            SpecialCaseE,
    input  logic [CNTW-1:0] CyclesE,
    input  logic            WZeroE,
    input  logic            StallM,
    input  logic            FlushE,
    output logic            IFDivStartE,
    output logic            FDivBusyE,
    output logic            FDivDoneE,
    output logic [CNTW-1:0] StepE
);

    fdivsqrt_state_t r_state;
    fdivsqrt_state_t w_state_nxt;

    logic            w_idle;
    logic            w_busy;
    logic            w_done;
    logic            w_cnt_clr;
    logic            w_cnt_load;
    logic            w_cnt_dec;
    logic            w_step_is_one;
    logic [CNTW-1:0] w_load_val;

    assign w_idle = (r_state == FDIVSQRT_IDLE);
    assign w_busy = (r_state == FDIVSQRT_BUSY);
    assign w_done = (r_state == FDIVSQRT_DONE);

    assign w_load_val = (CyclesE == '0) ? CNTW'(1) : CyclesE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FDIVSQRT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            FDIVSQRT_IDLE: begin
                if (!FlushE && FDivStartE) begin
                    if (SpecialCaseE) begin
                        w_state_nxt = FDIVSQRT_DONE;
                    end else begin
                        w_state_nxt = FDIVSQRT_BUSY;
                        w_cnt_load  = 1'b1;
                    end
                end
            end
            FDIVSQRT_BUSY: begin
                // Exit at StepE==1 so the decrement can never wrap.
                if (FlushE) begin
                    w_state_nxt = FDIVSQRT_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (w_step_is_one || WZeroE) begin
                    w_state_nxt = FDIVSQRT_DONE;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_dec   = 1'b1;
                end
            end
            FDIVSQRT_DONE: begin
                if (FlushE || !StallM) begin
                    w_state_nxt = FDIVSQRT_IDLE;
                end
            end
            default: begin
                w_state_nxt = FDIVSQRT_IDLE;
            end
        endcase
    end

    fdivsqrt_stepcnt #(
        .CNTW (CNTW)
    ) u_stepcnt (
        .clk           (clk),
        .reset         (reset),
        .i_clr         (w_cnt_clr),
        .i_load        (w_cnt_load),
        .i_load_val    (w_load_val),
        .i_dec         (w_cnt_dec),
        .o_step        (StepE),
        .o_step_is_one (w_step_is_one)
    );

    assign IFDivStartE = w_idle & FDivStartE & ~SpecialCaseE & ~FlushE;
    assign FDivBusyE   = IFDivStartE | w_busy;
    assign FDivDoneE   = w_done;

endmodule

`default_nettype wire
